// File: rtl/affine_pkg.sv
// affine: shared definitions for the affine PicoMIPS core and its program loader.
//   W_INST               instruction word width used by the core decoder
//   LOAD_BYTES_PER_WORD  stream bytes packed into one instruction word
//   tLoadState           program loader state encoding
//   tInstFields          op|i2|i1|rd|rs view of a word (op width = inst_w - 24)
//   split_inst()         splits a packed word into its fields
package affine;

    localparam int W_INST              = 28;
    localparam int LOAD_BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE, HDR, BYTE, WRITE, CHECK, DONE, ERR
    } tLoadState;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] i2;
        logic [7:0] i1;
        logic [3:0] rd;
        logic [3:0] rs;
    } tInstFields;

    // op occupies the bits above bit 23 that exist in an inst_w-bit word.
    function automatic tInstFields split_inst(input logic [31:0] w, input int inst_w);
        tInstFields f;
        logic [7:0] op_mask;
        op_mask = 8'(16'h00FF >> (32 - inst_w));
        f.op = w[31:24] & op_mask;
        f.i2 = w[23:16];
        f.i1 = w[15:8];
        f.rd = w[7:4];
        f.rs = w[3:0];
        return f;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the affine PicoMIPS core.
// Accepts a frame (HDR word count, then 4 bytes per word, MSB first) over a
// valid/ready handshake, packs each word and writes it to program memory,
// holding the core in reset until the frame has loaded.
// Optional build macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
//
// Ports:
//   clk        system clock
//   nReset     synchronous active-low reset
//   start      pulse: begin a load frame (IDLE, DONE or ERR only)
//   rx_data    stream byte
//   rx_valid   rx_data valid
//   rx_ready   loader accepts a byte this cycle
//   pm_we      program memory write strobe (one cycle per word)
//   pm_addr    program memory write address
//   pm_wdata   packed instruction word
//   core_hold  core held in reset while high
//   done       frame loaded, sticky until start/reset
//   err        frame rejected, sticky until start/reset
//   words      words written in the current or last frame
module prog_loader
    import affine::*;
#(
    parameter int ADDR_W = 4,
    parameter int INST_W = affine::W_INST
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [INST_W-1:0] pm_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words
);

    localparam int              DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_N = {1'b1, {ADDR_W{1'b0}}};
    // Bits of byte 0 that fall above the instruction word and must be zero.
    localparam logic [7:0]      HI_MASK = 8'(16'h00FF << (INST_W - 24));

    tLoadState           state;
    logic [1:0]          byte_cnt;
    logic [ADDR_W:0]     n_words;
    // Only the low INST_W-8 bits of the first three bytes are kept; the
    // discarded top bits of byte 0 are required to be zero anyway.
    logic [INST_W-9:0]   assembly;
    logic [INST_W-1:0]   word_next;
    logic                xfer;
    logic                hdr_bad;
    logic [ADDR_W:0]     hdr_n;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    always_comb begin
        xfer      = rx_valid && rx_ready;
        word_next = {assembly, rx_data};
        hdr_bad   = (int'(rx_data) > DEPTH);
        hdr_n     = (rx_data == 8'd0) ? DEPTH_N : (ADDR_W+1)'(rx_data);
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state     <= IDLE;
            rx_ready  <= 1'b0;
            pm_we     <= 1'b0;
            pm_addr   <= '0;
            pm_wdata  <= '0;
            core_hold <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            words     <= '0;
            byte_cnt  <= '0;
        end else begin
            pm_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= HDR;
                        rx_ready  <= 1'b1;
                        core_hold <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        words <= '0;
                        if (hdr_bad) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            rx_ready <= 1'b0;
                        end else begin
                            n_words  <= hdr_n;
                            pm_addr  <= '0;
                            byte_cnt <= '0;
                            state    <= BYTE;
                        end
`ifdef LOADER_CHECKSUM_EN
                        csum <= rx_data;
`endif
                    end
                end
                BYTE: begin
                    if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        if (byte_cnt == 2'd0 && (rx_data & HI_MASK) != 8'd0) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            rx_ready <= 1'b0;
                        end else begin
                            assembly <= (INST_W-8)'(word_next);
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                pm_we    <= 1'b1;
                                pm_wdata <= word_next;
                                rx_ready <= 1'b0;
                                state    <= WRITE;
                            end
                        end
                    end
                end
                WRITE: begin
                    words   <= words + 1'b1;
                    pm_addr <= pm_addr + 1'b1;
                    if (words + 1'b1 == n_words) begin
`ifdef LOADER_CHECKSUM_EN
                        state     <= CHECK;
`else
                        state     <= DONE;
                        rx_ready  <= 1'b0;
                        done      <= 1'b1;
                        core_hold <= 1'b0;
`endif
                    end else begin
                        state    <= BYTE;
                        rx_ready <= 1'b1;
                    end
`ifdef LOADER_CHECKSUM_EN
                    if (words + 1'b1 == n_words) begin
                        rx_ready <= 1'b1;
                    end
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (xfer) begin
                        rx_ready <= 1'b0;
                        if (rx_data == csum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    rx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
